// File: rtl/sync_fifo_fwft_pkg.sv
// Shared definitions for the show-ahead FIFO: depth helper, default thresholds
// and the per-cycle accept encoding.
package sync_fifo_fwft_pkg;

    localparam int unsigned DEFAULT_AE_THRESH = 2;
    localparam int unsigned AF_MARGIN         = 2;

    // {put_ok, get_ok} as seen at a clock edge
    typedef enum logic [1:0] {
        OP_IDLE = 2'b00,
        OP_POP  = 2'b01,
        OP_PUSH = 2'b10,
        OP_BOTH = 2'b11
    } fifo_op_e;

    function automatic int unsigned fifo_depth(input int unsigned p2);
        return 32'd1 << p2;
    endfunction

endpackage

// File: rtl/fifo_ram.sv
// Storage array for sync_fifo_fwft: synchronous write, asynchronous read so the
// head entry is visible without a bubble.
module fifo_ram #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned AW    = 5
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_fwft.sv
// Single-clock first-word-fall-through FIFO with almost-full/empty flags and
// sticky error flags. Define FIFO_HWM_EN to build the fillcount high-water mark.
module sync_fifo_fwft
    import sync_fifo_fwft_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned DEPTH_P2  = 5,
    parameter int unsigned AF_THRESH = fifo_depth(DEPTH_P2) - AF_MARGIN,
    parameter int unsigned AE_THRESH = DEFAULT_AE_THRESH
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [WIDTH-1:0]    data_in,
    input  logic                put,
    input  logic                get,
    output logic [WIDTH-1:0]    data_out,
    output logic                empty_bar,
    output logic                full_bar,
    output logic [DEPTH_P2:0]   fillcount,
    output logic                almost_full,
    output logic                almost_empty,
    output logic                overflow,
    output logic                underflow,
    output logic [DEPTH_P2:0]   hwm
);

    localparam int unsigned CW = DEPTH_P2 + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(fifo_depth(DEPTH_P2));
    localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);
    localparam logic [CW-1:0] AE_C    = CW'(AE_THRESH);

    logic [DEPTH_P2-1:0] wr_ptr;
    logic [DEPTH_P2-1:0] rd_ptr;
    logic [CW-1:0]       count;
    logic [CW-1:0]       count_nxt;
    logic                put_ok;
    logic                get_ok;
    fifo_op_e            op;
    logic [WIDTH-1:0]    rdata;

    fifo_ram #(
        .WIDTH (WIDTH),
        .AW    (DEPTH_P2)
    ) u_ram (
        .clk   (clk),
        .we    (put_ok),
        .waddr (wr_ptr),
        .wdata (data_in),
        .raddr (rd_ptr),
        .rdata (rdata)
    );

    always_comb begin
        empty_bar    = (count != '0);
        full_bar     = (count != DEPTH_C);
        almost_full  = (count >= AF_C);
        almost_empty = (count <= AE_C);
        fillcount    = count;
        // A full FIFO still accepts a put when the head is popped in the same cycle
        put_ok       = put & (full_bar | get);
        get_ok       = get & empty_bar;
        op           = fifo_op_e'({put_ok, get_ok});
        count_nxt    = count;
        case (op)
            OP_PUSH: count_nxt = count + 1'b1;
            OP_POP:  count_nxt = count - 1'b1;
            default: count_nxt = count;
        endcase
        // Array is not cleared by reset, so mask the head while empty
        data_out     = empty_bar ? rdata : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (put_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (get_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count_nxt;
            if (put & ~put_ok) begin
                overflow <= 1'b1;
            end
            if (get & ~empty_bar) begin
                underflow <= 1'b1;
            end
        end
    end

`ifdef FIFO_HWM_EN
    logic [CW-1:0] hwm_q;

    // count_nxt never exceeds the depth, so the mark saturates on its own
    always_ff @(posedge clk) begin
        if (reset) begin
            hwm_q <= '0;
        end else if (count_nxt > hwm_q) begin
            hwm_q <= count_nxt;
        end
    end

    assign hwm = hwm_q;
`else
    assign hwm = '0;
`endif

endmodule

// File: tb/tb_sync_fifo_fwft.sv
// Self-checking bench for sync_fifo_fwft (WIDTH=8, depth 4, AF=3, AE=1), with a
// queue-based reference model; honours FIFO_HWM_EN for the hwm expectations.
module tb_sync_fifo_fwft;

    localparam int unsigned D  = 4;
    localparam int unsigned AF = 3;
    localparam int unsigned AE = 1;

    logic       clk = 1'b0;
    logic       reset, put, get;
    logic [7:0] data_in, data_out;
    logic       empty_bar, full_bar, almost_full, almost_empty, overflow, underflow;
    logic [2:0] fillcount, hwm;

    int checks = 0;
    int errors = 0;

    logic [7:0]  q[$];
    logic        m_ovf, m_unf;
    int unsigned m_hwm;

    typedef struct {
        logic        put;
        logic        get;
        logic [7:0]  din;
        int unsigned fill;
        logic [7:0]  head;
        logic        ovf;
        logic        unf;
    } vec_t;

    vec_t tbl[11];

    sync_fifo_fwft #(
        .WIDTH     (8),
        .DEPTH_P2  (2),
        .AF_THRESH (AF),
        .AE_THRESH (AE)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .data_in      (data_in),
        .put          (put),
        .get          (get),
        .data_out     (data_out),
        .empty_bar    (empty_bar),
        .full_bar     (full_bar),
        .fillcount    (fillcount),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .overflow     (overflow),
        .underflow    (underflow),
        .hwm          (hwm)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] exp_hwm();
`ifdef FIFO_HWM_EN
        return m_hwm;
`else
        return 32'd0;
`endif
    endfunction

    // Apply one cycle of inputs, advance the reference model, sample #1 after the edge
    task automatic drive(input logic r, input logic p, input logic g, input logic [7:0] d);
        int unsigned n;
        logic pok, gok;
        reset = r; put = p; get = g; data_in = d;
        if (r) begin
            q.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
            m_hwm = 0;
        end else begin
            n   = q.size();
            pok = p && ((n < D) || g);
            gok = g && (n > 0);
            if (p && !pok) m_ovf = 1'b1;
            if (g && n == 0) m_unf = 1'b1;
            if (gok) void'(q.pop_front());
            if (pok) q.push_back(d);
            if (q.size() > m_hwm) m_hwm = q.size();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_model(input string tag);
        int unsigned n;
        n = q.size();
        chk({tag, ".fill"},   32'(fillcount),    n);
        chk({tag, ".empty"},  32'(empty_bar),    32'(n > 0));
        chk({tag, ".full"},   32'(full_bar),     32'(n < D));
        chk({tag, ".af"},     32'(almost_full),  32'(n >= AF));
        chk({tag, ".ae"},     32'(almost_empty), 32'(n <= AE));
        chk({tag, ".ovf"},    32'(overflow),     32'(m_ovf));
        chk({tag, ".unf"},    32'(underflow),    32'(m_unf));
        chk({tag, ".hwm"},    32'(hwm),          exp_hwm());
        if (n > 0) chk({tag, ".head"}, 32'(data_out), 32'(q[0]));
    endtask

    task automatic mstep(input string tag, input logic r, input logic p, input logic g,
                         input logic [7:0] d);
        drive(r, p, g, d);
        check_model(tag);
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, ".fill"},  32'(fillcount),    0);
        chk({tag, ".dout"},  32'(data_out),     0);
        chk({tag, ".empty"}, 32'(empty_bar),    0);
        chk({tag, ".full"},  32'(full_bar),     1);
        chk({tag, ".af"},    32'(almost_full),  0);
        chk({tag, ".ae"},    32'(almost_empty), 1);
        chk({tag, ".ovf"},   32'(overflow),     0);
        chk({tag, ".unf"},   32'(underflow),    0);
        chk({tag, ".hwm"},   32'(hwm),          0);
    endtask

    initial begin
        reset = 1'b1; put = 1'b0; get = 1'b0; data_in = '0;

        tbl[0]  = '{1'b1, 1'b0, 8'hA1, 1, 8'hA1, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 1'b1, 8'h00, 0, 8'h00, 1'b0, 1'b0};
        tbl[2]  = '{1'b1, 1'b0, 8'h01, 1, 8'h01, 1'b0, 1'b0};
        tbl[3]  = '{1'b1, 1'b0, 8'h02, 2, 8'h01, 1'b0, 1'b0};
        tbl[4]  = '{1'b1, 1'b0, 8'h03, 3, 8'h01, 1'b0, 1'b0};
        tbl[5]  = '{1'b1, 1'b0, 8'h04, 4, 8'h01, 1'b0, 1'b0};
        tbl[6]  = '{1'b1, 1'b0, 8'h05, 4, 8'h01, 1'b1, 1'b0};
        tbl[7]  = '{1'b0, 1'b1, 8'h00, 3, 8'h02, 1'b1, 1'b0};
        tbl[8]  = '{1'b0, 1'b1, 8'h00, 2, 8'h03, 1'b1, 1'b0};
        tbl[9]  = '{1'b0, 1'b1, 8'h00, 1, 8'h04, 1'b1, 1'b0};
        tbl[10] = '{1'b0, 1'b1, 8'h00, 0, 8'h00, 1'b1, 1'b0};

        drive(1'b1, 1'b0, 1'b0, 8'h00);
        drive(1'b1, 1'b1, 1'b1, 8'hFF);
        check_reset_state("rst0");

        // Plan items 1-2: single write, fill to full, rejected put, drain
        for (int i = 0; i < 11; i++) begin
            drive(1'b0, tbl[i].put, tbl[i].get, tbl[i].din);
            chk($sformatf("tbl%0d.fill", i), 32'(fillcount),    tbl[i].fill);
            chk($sformatf("tbl%0d.empty", i), 32'(empty_bar),   32'(tbl[i].fill > 0));
            chk($sformatf("tbl%0d.full", i), 32'(full_bar),     32'(tbl[i].fill < D));
            chk($sformatf("tbl%0d.af", i),   32'(almost_full),  32'(tbl[i].fill >= AF));
            chk($sformatf("tbl%0d.ae", i),   32'(almost_empty), 32'(tbl[i].fill <= AE));
            chk($sformatf("tbl%0d.ovf", i),  32'(overflow),     32'(tbl[i].ovf));
            chk($sformatf("tbl%0d.unf", i),  32'(underflow),    32'(tbl[i].unf));
            if (tbl[i].fill > 0)
                chk($sformatf("tbl%0d.head", i), 32'(data_out), 32'(tbl[i].head));
        end

        // Plan item 3: put into full FIFO with simultaneous get
        mstep("p3.rst", 1'b1, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 4; i++) mstep("p3.fill", 1'b0, 1'b1, 1'b0, 8'(8'h10 + i));
        mstep("p3.pg", 1'b0, 1'b1, 1'b1, 8'h14);
        chk("p3.head", 32'(data_out), 32'h11);
        chk("p3.ovf",  32'(overflow), 0);
        for (int i = 0; i < 4; i++) mstep("p3.drain", 1'b0, 1'b0, 1'b1, 8'h00);

        // Plan item 4: get on empty with simultaneous put
        mstep("p4", 1'b0, 1'b1, 1'b1, 8'h55);
        chk("p4.unf",  32'(underflow), 1);
        chk("p4.head", 32'(data_out),  32'h55);

        // Plan item 5: streaming with put=get, pointers wrap
        for (int i = 0; i < 10; i++) mstep("p5.stream", 1'b0, 1'b1, 1'b1, 8'(8'h60 + i));
        chk("p5.fill", 32'(fillcount), 1);
        chk("p5.head", 32'(data_out),  32'h69);

        // Plan item 6: high-water mark, then reset mid-burst
        mstep("p6.rst", 1'b1, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 3; i++) mstep("p6.fill", 1'b0, 1'b1, 1'b0, 8'(8'h30 + i));
        for (int i = 0; i < 3; i++) mstep("p6.drain", 1'b0, 1'b0, 1'b1, 8'h00);
`ifdef FIFO_HWM_EN
        chk("p6.hwm", 32'(hwm), 3);
`else
        chk("p6.hwm", 32'(hwm), 0);
`endif
        mstep("p6.burst", 1'b0, 1'b1, 1'b0, 8'h41);
        mstep("p6.burst", 1'b0, 1'b1, 1'b1, 8'h42);
        mstep("p6.midrst", 1'b1, 1'b1, 1'b1, 8'h43);
        check_reset_state("p6.rst");

        // Randomised traffic with phased put/get bias and occasional reset
        for (int i = 0; i < 600; i++) begin
            int unsigned pp, gp;
            logic r;
            pp = ((i / 50) % 3 == 0) ? 85 : (((i / 50) % 3 == 1) ? 20 : 55);
            gp = 100 - pp;
            r  = ($urandom_range(0, 79) == 0);
            mstep($sformatf("rnd%0d", i), r, $urandom_range(0, 99) < pp,
                  $urandom_range(0, 99) < gp, 8'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
